// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, dmem wait watchdog.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/load-use performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Mem_Read_ID_EX,
  input  logic [4:0]       rd_ID_EX,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             Mem_Read_EX_MEM,
  input  logic             Mem_Write_EX_MEM,
  input  logic             PcSrc_EX_MEM,
  input  logic             zero_EX_MEM,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  state_e     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  logic w_mem_op;
  logic w_br_taken;
  logic w_lu_hz;
  logic w_mem_stall;

  assign w_mem_op    = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign w_br_taken  = PcSrc_EX_MEM & zero_EX_MEM;
  assign w_lu_hz     = Mem_Read_ID_EX & (rd_ID_EX != 5'd0) &
                       ((rd_ID_EX == rs1_IF_ID) | (rd_ID_EX == rs2_IF_ID));
  // dmem_ready is only meaningful when an access is actually pending.
  assign w_mem_stall = w_mem_op & ~dmem_ready;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = 1'b0;
    case (r_state)
      StRun, StMemWait: begin
        dmem_req = w_mem_op | (r_state == StMemWait);
        if (w_mem_stall) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
        end else if (w_br_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (w_lu_hz) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      default: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
    endcase
    // Whole pipeline frozen with no request while reset is held.
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_req      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StRun;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_mem_stall) begin
            r_state    <= StMemWait;
            r_wait_cnt <= 8'd1;
          end
        end
        StMemWait: begin
          if (!w_mem_stall) begin
            r_state    <= StRun;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt >= WaitMax) begin
            r_state   <= StError;
            r_timeout <= 1'b1;
          end else if (r_wait_cnt != 8'hff) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        StError: begin
          r_timeout <= 1'b1;
        end
        default: begin
          r_state <= StRun;
        end
      endcase
    end
  end

  assign mem_timeout = r_timeout;
  assign state       = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic             w_flush_fire;
  logic             w_lu_fire;

  // A load-use bubble is an ID_EX flush that is not part of a branch flush.
  assign w_flush_fire = ex_mem_flush;
  assign w_lu_fire    = id_ex_flush & ~ex_mem_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if ((r_state == StMemWait) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_fire && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_lu_fire && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign lu_cnt    = r_lu_cnt;
`endif

endmodule
